// File: rtl/des_pkg.sv
// des_pkg: widths, permutation tables, S-boxes and FSM state type
// shared by the DES round controller, key schedule and f block.
package des_pkg;

    localparam int BLK_W    = 64;
    localparam int KEY_W    = 64;
    localparam int HALF_W   = 32;
    localparam int SUBKEY_W = 48;
    localparam int CD_W     = 28;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam int unsigned SHIFT_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    // Tables hold DES bit numbers, 1 = most significant bit.
    localparam int unsigned IP_T [64] = '{
        58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
        62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
        57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
        61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};

    localparam int unsigned FP_T [64] = '{
        40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
        38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
        36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
        34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};

    localparam int unsigned PC1_T [56] = '{
        57,49,41,33,25,17,9,  1,58,50,42,34,26,18,
        10,2,59,51,43,35,27,  19,11,3,60,52,44,36,
        63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
        14,6,61,53,45,37,29,  21,13,5,28,20,12,4};

    localparam int unsigned PC2_T [48] = '{
        14,17,11,24,1,5,   3,28,15,6,21,10,
        23,19,12,4,26,8,   16,7,27,20,13,2,
        41,52,31,37,47,55, 30,40,51,45,33,48,
        44,49,39,56,34,53, 46,42,50,36,29,32};

    localparam int unsigned E_T [48] = '{
        32,1,2,3,4,5,      4,5,6,7,8,9,
        8,9,10,11,12,13,   12,13,14,15,16,17,
        16,17,18,19,20,21, 20,21,22,23,24,25,
        24,25,26,27,28,29, 28,29,30,31,32,1};

    localparam int unsigned P_T [32] = '{
        16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
        2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};

    // Each S-box: 64 nibbles, entry row*16+col, entry 0 in the top nibble.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    function automatic logic [BLK_W-1:0] ip_perm(input logic [BLK_W-1:0] x);
        logic [BLK_W-1:0] y;
        for (int j = 0; j < 64; j++) y[63-j] = x[64-IP_T[j]];
        return y;
    endfunction

    function automatic logic [BLK_W-1:0] fp_perm(input logic [BLK_W-1:0] x);
        logic [BLK_W-1:0] y;
        for (int j = 0; j < 64; j++) y[63-j] = x[64-FP_T[j]];
        return y;
    endfunction

    function automatic logic [2*CD_W-1:0] pc1_perm(input logic [KEY_W-1:0] x);
        logic [2*CD_W-1:0] y;
        for (int j = 0; j < 56; j++) y[55-j] = x[64-PC1_T[j]];
        return y;
    endfunction

    function automatic logic [SUBKEY_W-1:0] pc2_perm(input logic [2*CD_W-1:0] x);
        logic [SUBKEY_W-1:0] y;
        for (int j = 0; j < 48; j++) y[47-j] = x[56-PC2_T[j]];
        return y;
    endfunction

    function automatic logic [SUBKEY_W-1:0] e_perm(input logic [HALF_W-1:0] x);
        logic [SUBKEY_W-1:0] y;
        for (int j = 0; j < 48; j++) y[47-j] = x[32-E_T[j]];
        return y;
    endfunction

    function automatic logic [HALF_W-1:0] p_perm(input logic [HALF_W-1:0] x);
        logic [HALF_W-1:0] y;
        for (int j = 0; j < 32; j++) y[31-j] = x[32-P_T[j]];
        return y;
    endfunction

    function automatic logic [HALF_W-1:0] sbox_sub(input logic [SUBKEY_W-1:0] x);
        logic [HALF_W-1:0] y;
        logic [5:0] six;
        logic [5:0] idx;
        for (int s = 0; s < 8; s++) begin
            six = x[47-6*s -: 6];
            idx = {six[5], six[0], six[4:1]};
            y[31-4*s -: 4] = SBOX[s][255-4*idx -: 4];
        end
        return y;
    endfunction

endpackage

// File: rtl/des_key_sched.sv
// des_key_sched: C/D key halves, per-round rotation and PC2 subkey.
// Reverse subkey order (right rotations) exists only with DES_DECRYPT_EN.
module des_key_sched
    import des_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                step,
    input  logic                decrypt,
    input  logic [3:0]          round,
    input  logic [KEY_W-1:0]    key,
    output logic [SUBKEY_W-1:0] subkey
);

    logic [CD_W-1:0] c_q, d_q, c_rot, d_rot;
    logic dbl;

    assign dbl = (SHIFT_T[round] == 2);

    function automatic logic [CD_W-1:0] rotl(input logic [CD_W-1:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

`ifdef DES_DECRYPT_EN
    function automatic logic [CD_W-1:0] rotr(input logic [CD_W-1:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    // rotate C/D for this round: left for encrypt, right (none first) for decrypt
    always_comb begin
        c_rot = c_q;
        d_rot = d_q;
        unique case (1'b1)
            !decrypt: begin
                c_rot = rotl(c_q, dbl);
                d_rot = rotl(d_q, dbl);
            end
            decrypt && (round == 4'd0): begin
                c_rot = c_q;
                d_rot = d_q;
            end
            decrypt && (round != 4'd0): begin
                c_rot = rotr(c_q, dbl);
                d_rot = rotr(d_q, dbl);
            end
            default: ;
        endcase
    end
`else
    logic unused_decrypt;
    assign unused_decrypt = decrypt;

    // rotate C/D left for this round (encrypt-only build)
    always_comb begin
        c_rot = rotl(c_q, dbl);
        d_rot = rotl(d_q, dbl);
    end
`endif

    assign subkey = pc2_perm({c_rot, d_rot});

    // C/D load on accept, advance by one round per step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q <= '0;
            d_q <= '0;
        end else if (load) begin
            {c_q, d_q} <= pc1_perm(key);
        end else if (step) begin
            c_q <= c_rot;
            d_q <= d_rot;
        end
    end

endmodule

// File: rtl/fblock.sv
// fblock: DES round function f(R, K) = P(S(E(R) ^ K)).
// Purely combinational; one instance is shared by all rounds.
module fblock
    import des_pkg::*;
(
    input  logic [HALF_W-1:0]   r,
    input  logic [SUBKEY_W-1:0] k,
    output logic [HALF_W-1:0]   f
);

    assign f = p_perm(sbox_sub(e_perm(r) ^ k));

endmodule

// File: rtl/des_round_ctrl.sv
// des_round_ctrl: iterative DES, one round per clock, valid/ready both sides.
// Optional DES_DECRYPT_EN adds decrypt mode (reverse subkey order).
module des_round_ctrl
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_block,
    input  logic [KEY_W-1:0] in_key,
    input  logic             in_decrypt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_block,
    output logic             busy
);

    localparam logic [3:0] LAST = 4'(NUM_ROUNDS - 1);

    state_t state, nxt;
    logic [3:0] cnt;
    logic [HALF_W-1:0] l_q, r_q, f_out, r_nxt;
    logic [SUBKEY_W-1:0] ki;
    logic [BLK_W-1:0] ip_blk;
    logic load, step, last, mode;

`ifdef DES_DECRYPT_EN
    // job direction captured on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mode <= 1'b0;
        else if (load) mode <= in_decrypt;
    end
`else
    logic unused_in_decrypt;
    assign unused_in_decrypt = in_decrypt;
    assign mode = 1'b0;
`endif

    assign last      = (cnt == LAST);
    assign ip_blk    = ip_perm(in_block);
    assign r_nxt     = l_q ^ f_out;
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

    des_key_sched u_ks (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .step    (step),
        .decrypt (mode),
        .round   (cnt),
        .key     (in_key),
        .subkey  (ki)
    );

    fblock u_f (
        .r (r_q),
        .k (ki),
        .f (f_out)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= nxt;
    end

    // next state and datapath strobes
    always_comb begin
        nxt  = state;
        load = 1'b0;
        step = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    load = 1'b1;
                    nxt  = ROUND;
                end
            end
            ROUND: begin
                step = 1'b1;
                if (last) nxt = DONE;
            end
            DONE: begin
                if (out_ready) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // L/R Feistel rounds, counter, and final-swap result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_q       <= '0;
            r_q       <= '0;
            cnt       <= '0;
            out_block <= '0;
        end else if (load) begin
            l_q <= ip_blk[63:32];
            r_q <= ip_blk[31:0];
            cnt <= '0;
        end else if (step) begin
            l_q <= r_q;
            r_q <= r_nxt;
            if (!last) cnt <= cnt + 4'd1;
            else out_block <= fp_perm({r_nxt, r_q});
        end
    end

endmodule

// File: tb/tb_des_round_ctrl.sv
// tb_des_round_ctrl: directed vectors plus random traffic, checked each
// cycle against a bench-side DES and handshake-timing model.
module tb_des_round_ctrl;
    import des_pkg::*;

    localparam int NR  = 16;
    localparam int LAT = NR + 1;
    localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
    localparam logic [63:0] P1  = 64'h0123456789ABCDEF;
    localparam logic [63:0] C1  = 64'h85E813540F0AB405;
    localparam logic [63:0] K2  = 64'h0E329232EA6D0D73;
    localparam logic [63:0] P2  = 64'h8787878787878787;
    localparam logic [63:0] PAR = 64'h0101010101010101;
`ifdef DES_DECRYPT_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic in_valid = 1'b0;
    logic in_decrypt = 1'b0;
    logic out_ready = 1'b1;
    logic in_ready, out_valid, busy;
    logic [63:0] in_block = '0;
    logic [63:0] in_key = '0;
    logic [63:0] out_block;
    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    des_round_ctrl #(.NUM_ROUNDS(NR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_block   (in_block),
        .in_key     (in_key),
        .in_decrypt (in_decrypt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_block  (out_block),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
        logic [55:0] y;
        y = {x, x} << n;
        return y[55:28];
    endfunction

    // Whole-block DES: full subkey list from cumulative shifts, then 16 rounds.
    function automatic logic [63:0] des_ref(input logic [63:0] blk, input logic [63:0] key,
                                            input bit dec);
        logic [55:0] cd;
        logic [47:0] ks [16];
        logic [63:0] lr;
        logic [31:0] l, r, t;
        int tot;
        tot = 0;
        cd = pc1_perm(key);
        for (int i = 0; i < 16; i++) begin
            tot += int'(SHIFT_T[i]);
            ks[i] = pc2_perm({rotl28(cd[55:28], tot), rotl28(cd[27:0], tot)});
        end
        lr = ip_perm(blk);
        l = lr[63:32];
        r = lr[31:0];
        for (int i = 0; i < 16; i++) begin
            t = r;
            r = l ^ p_perm(sbox_sub(e_perm(r) ^ (dec ? ks[15-i] : ks[i])));
            l = t;
        end
        return fp_perm({r, l});
    endfunction

    bit m_job = 1'b0;
    int m_age = 0;
    logic [63:0] m_exp = '0;

    // reference timing: a job exists from accept until drained; result due LAT edges after accept
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_job = 1'b0;
            m_age = 0;
        end else if (!m_job) begin
            if (in_valid) begin
                m_job = 1'b1;
                m_age = 1;
                m_exp = des_ref(in_block, in_key, in_decrypt && DEC_EN);
            end
        end else if (m_age >= LAT) begin
            if (out_ready) m_job = 1'b0;
        end else begin
            m_age++;
        end
    end

    // every cycle: handshake flags and result against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check64("in_ready", in_ready, !m_job);
            check64("busy", busy, m_job);
            check64("out_valid", out_valid, m_job && m_age >= LAT);
            if (!rst_n) check64("rst_out_block", out_block, 64'h0);
            else if (m_job && m_age >= LAT) check64("out_block", out_block, m_exp);
        end
    end

    task automatic send(input logic [63:0] b, input logic [63:0] k, input bit d);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        in_block = b;
        in_key = k;
        in_decrypt = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check64("accept_wait", 64'(n < 100), 64'h1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        logic [63:0] want;

        #2 rst_n = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;

        check64("model_enc", des_ref(P1, K1, 1'b0), C1);
        check64("model_k2", des_ref(P2, K2, 1'b0), 64'h0);
        check64("model_dec", des_ref(C1, K1, 1'b1), P1);

        send(P1, K1, 1'b0);
        wait_out(lat);
        check64("latency", 64'(lat), 64'(LAT));
        check64("enc_vec", out_block, C1);

        send(C1, K1, 1'b1);
        wait_out(lat);
        want = DEC_EN ? P1 : des_ref(C1, K1, 1'b0);
        check64("dec_vec", out_block, want);

        @(posedge clk);
        #1 out_ready = 1'b0;
        send(P2, K2, 1'b0);
        wait_out(lat);
        repeat (10) begin
            check64("bp_hold", out_block, 64'h0);
            check64("bp_in_ready", in_ready, 1'b0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check64("bp_release", in_ready, 1'b1);
        out_ready = 1'b1;

        send(P1, K1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        in_block = P2;
        in_key = K2;
        in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1 in_valid = 1'b0;
        wait_out(lat);
        check64("busy_ignore", out_block, C1);
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            check64("no_second_job", busy, 1'b0);
        end

        send(P1, K1, 1'b0);
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check64("rst_round_valid", out_valid, 1'b0);
        check64("rst_round_ready", in_ready, 1'b1);
        check64("rst_round_busy", busy, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        send(P1, K1, 1'b0);
        wait_out(lat);
        check64("post_rst_vec", out_block, C1);

        @(posedge clk);
        #1 out_ready = 1'b0;
        send(P2, K2, 1'b0);
        wait_out(lat);
        #1 rst_n = 1'b0;
        #1;
        check64("rst_done_valid", out_valid, 1'b0);
        check64("rst_done_block", out_block, 64'h0);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;

        send(P1, K1 ^ PAR, 1'b0);
        wait_out(lat);
        check64("parity_flip", out_block, C1);
        send(P1, K1 & ~PAR, 1'b0);
        wait_out(lat);
        check64("parity_clear", out_block, C1);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            in_valid = ($urandom_range(0, 3) == 0);
            in_block = {$urandom, $urandom};
            in_key = {$urandom, $urandom};
            in_decrypt = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                #3 rst_n = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check64("drained", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
